// File: rtl/line_demux_store_pkg.sv
// Shared types and helpers for the line write-demux store: refill FSM encoding,
// default select width, and the slot-slice macro used to address the packed data bus.
package line_demux_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int WIDTH_DEF = 32;
  localparam int SEL_W     = $clog2(WIDTH_DEF);

  // Beat counter must reach BURST_LEN itself, hence the +1.
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

`ifndef LDS_SLOT
`define LDS_SLOT(k, w) ((k)*(w)) +: (w)
`endif

// File: rtl/line_wr_decoder.sv
// Slot select decoder: binary select to one-hot write enable, gated by en_i.
module line_wr_decoder #(
  parameter int WIDTH = 32,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/line_demux_store.sv
// Write side of the cache line-select path: single indexed writes plus a valid/ready
// refill burst into WIDTH slots, exposed as a packed, fully registered data bus.
module line_demux_store
  import line_demux_store_pkg::*;
#(
  parameter int line_width = 3,
  parameter int WIDTH      = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(WIDTH)-1:0]      wr_sel,
  input  logic [line_width-1:0]         wr_data,
  input  logic                          inv_all,
  input  logic                          fill_start,
  input  logic [$clog2(WIDTH)-1:0]      fill_base,
  input  logic                          fill_valid,
  input  logic [line_width-1:0]         fill_data,
  output logic                          fill_ready,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic [line_width*WIDTH-1:0]   data_out,
  output logic [WIDTH-1:0]              valid_out
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = cnt_w(BURST_LEN);

  fill_state_e                        state_q;
  logic [SW-1:0]                      ptr_q;
  logic [CW-1:0]                      cnt_q;
  logic                               fill_ready_q, fill_busy_q, fill_done_q;
  logic [WIDTH-1:0][line_width-1:0]   data_q, data_d;
  logic [WIDTH-1:0]                   valid_q, valid_d;
  logic [WIDTH-1:0]                   wr_oh, fl_oh;
  logic                               beat, last_beat;

  // fill_ready_q is high exactly while in FILL, so it doubles as the state qualifier.
  assign beat      = fill_valid & fill_ready_q;
  assign last_beat = (cnt_q == CW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      fill_ready_q <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fill_start) begin
            state_q      <= ST_FILL;
            ptr_q        <= fill_base;
            cnt_q        <= '0;
            fill_ready_q <= 1'b1;
            fill_busy_q  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (beat) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q      <= ST_DONE;
              fill_ready_q <= 1'b0;
              fill_done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          fill_done_q <= 1'b0;
          fill_busy_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          fill_ready_q <= 1'b0;
          fill_busy_q  <= 1'b0;
          fill_done_q  <= 1'b0;
        end
      endcase
    end
  end

  line_wr_decoder #(.WIDTH(WIDTH), .SEL_W(SW)) u_wr_dec (
    .en_i     (wr_en),
    .sel_i    (wr_sel),
    .onehot_o (wr_oh)
  );

  line_wr_decoder #(.WIDTH(WIDTH), .SEL_W(SW)) u_fl_dec (
    .en_i     (beat),
    .sel_i    (ptr_q),
    .onehot_o (fl_oh)
  );

  // CPU write beats the refill beat on a shared slot; inv_all overrides any valid set.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (wr_oh[k])      data_d[k] = wr_data;
      else if (fl_oh[k]) data_d[k] = fill_data;
      valid_d[k] = inv_all ? 1'b0 : (valid_q[k] | wr_oh[k] | fl_oh[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_slot
    assign data_out[`LDS_SLOT(k, line_width)] = data_q[k];
  end

  assign valid_out  = valid_q;
  assign fill_ready = fill_ready_q;
  assign fill_busy  = fill_busy_q;
  assign fill_done  = fill_done_q;

endmodule

// File: tb/tb_line_demux_store.sv
// Self-checking bench for line_demux_store: directed scenarios plus a random run,
// all compared against a slot-array reference model advanced once per clock.
module tb_line_demux_store;

  localparam int LW = 3;
  localparam int W  = 32;
  localparam int BL = 4;
  localparam int P_IDLE = 0, P_FILL = 1, P_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, inv_all, fill_start, fill_valid;
  logic [4:0]    wr_sel, fill_base;
  logic [LW-1:0] wr_data, fill_data;
  logic          fill_ready, fill_busy, fill_done;
  logic [LW*W-1:0] data_out;
  logic [W-1:0]  valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  int m_data[W];
  bit m_valid[W];
  int m_phase, m_ptr, m_cnt;

  line_demux_store #(.line_width(LW), .WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .inv_all(inv_all), .fill_start(fill_start), .fill_base(fill_base),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_busy(fill_busy), .fill_done(fill_done), .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Advance the reference model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    int nd[W]; bit nv[W]; int np, nptr, ncnt; bit beat;
    nd = m_data; nv = m_valid; np = m_phase; nptr = m_ptr; ncnt = m_cnt;
    if (!rst_n) begin
      for (int k = 0; k < W; k++) begin nd[k] = 0; nv[k] = 0; end
      np = P_IDLE; nptr = 0; ncnt = 0;
    end else begin
      beat = (m_phase == P_FILL) && fill_valid;
      if (beat) begin nd[m_ptr] = fill_data; nv[m_ptr] = 1; end
      if (wr_en) begin nd[wr_sel] = wr_data; nv[wr_sel] = 1; end
      if (inv_all) for (int k = 0; k < W; k++) nv[k] = 0;
      if (m_phase == P_IDLE && fill_start) begin
        np = P_FILL; nptr = fill_base; ncnt = 0;
      end else if (m_phase == P_FILL && beat) begin
        nptr = (m_ptr + 1) % W; ncnt = m_cnt + 1;
        if (ncnt == BL) np = P_DONE;
      end else if (m_phase == P_DONE) begin
        np = P_IDLE;
      end
    end
    @(posedge clk);
    m_data = nd; m_valid = nv; m_phase = np; m_ptr = nptr; m_cnt = ncnt;
    #1;
  endtask

  function automatic logic [LW*W-1:0] exp_bus();
    logic [LW*W-1:0] b;
    for (int k = 0; k < W; k++) b[k*LW +: LW] = LW'(m_data[k]);
    return b;
  endfunction

  function automatic logic [W-1:0] exp_valid();
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [2:0] exp_flags();
    return {m_phase == P_FILL, m_phase != P_IDLE, m_phase == P_DONE};
  endfunction

  function automatic logic [LW-1:0] slot(input int k);
    return data_out[k*LW +: LW];
  endfunction

  task automatic idle_inputs();
    rst_n = 1; wr_en = 0; wr_sel = 0; wr_data = 0; inv_all = 0;
    fill_start = 0; fill_base = 0; fill_valid = 0; fill_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; wr_en = 1; wr_sel = 5'd9; wr_data = 3'd6;
    tick(); tick();
    n_checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %h want 0", data_out); else n_pass++;
    n_checks++;
    if (valid_out !== '0) $display("FAIL reset_valid: got %h want 0", valid_out); else n_pass++;
    n_checks++;
    if ({fill_ready, fill_busy, fill_done} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {fill_ready, fill_busy, fill_done});
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_write();
    wr_en = 1; wr_sel = 5'd5; wr_data = 3'b101;
    tick();
    wr_en = 0;
    n_checks++;
    if (data_out[17:15] !== 3'b101) $display("FAIL single_slot5: got %b want 101", data_out[17:15]);
    else n_pass++;
    n_checks++;
    if (valid_out !== 32'h0000_0020) $display("FAIL single_valid: got %h want 00000020", valid_out);
    else n_pass++;
    n_checks++;
    if ((data_out & ~({{(LW*W-3){1'b0}}, 3'b111} << 15)) !== '0)
      $display("FAIL single_others: got %h want zero outside slot 5", data_out);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_sel = 5'($urandom_range(0, W-1)); wr_data = 3'($urandom);
      tick();
      n_checks++;
      if (data_out !== exp_bus() || valid_out !== exp_valid())
        $display("FAIL single_rand: got %h/%h want %h/%h", data_out, valid_out, exp_bus(), exp_valid());
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_wrapped_burst();
    int done_seen, done_cycle, cyc;
    done_seen = 0; done_cycle = -1; cyc = 0;
    fill_start = 1; fill_base = 5'd30;
    tick();
    fill_start = 0;
    n_checks++;
    if ({fill_ready, fill_busy, fill_done} !== 3'b110)
      $display("FAIL burst_enter: got %b want 110", {fill_ready, fill_busy, fill_done});
    else n_pass++;
    for (int b = 1; b <= BL; b++) begin
      fill_valid = 1; fill_data = 3'(b);
      tick(); cyc++;
      if (fill_done) begin done_seen++; done_cycle = cyc; end
      fill_valid = 0;
      if (b < BL) begin
        tick(); cyc++;
        if (fill_done) begin done_seen++; done_cycle = cyc; end
      end
    end
    n_checks++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b1 || fill_ready !== 1'b0)
      $display("FAIL burst_done_pulse: got d%b b%b r%b want d1 b1 r0", fill_done, fill_busy, fill_ready);
    else n_pass++;
    tick();
    if (fill_done) done_seen++;
    n_checks++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0)
      $display("FAIL burst_busy_fall: got b%b d%b want b0 d0", fill_busy, fill_done);
    else n_pass++;
    n_checks++;
    if (done_seen !== 1 || done_cycle !== 2*BL-1)
      $display("FAIL burst_done_once: got %0d pulses at %0d want 1 at %0d", done_seen, done_cycle, 2*BL-1);
    else n_pass++;
    n_checks++;
    if ({slot(30), slot(31), slot(0), slot(1)} !== {3'd1, 3'd2, 3'd3, 3'd4})
      $display("FAIL burst_wrap_slots: got %0d %0d %0d %0d want 1 2 3 4", slot(30), slot(31), slot(0), slot(1));
    else n_pass++;
    n_checks++;
    if (valid_out[31:30] !== 2'b11 || valid_out[1:0] !== 2'b11 || valid_out !== exp_valid())
      $display("FAIL burst_valid: got %h want %h", valid_out, exp_valid());
    else n_pass++;
  endtask

  task automatic test_collision();
    fill_start = 1; fill_base = 5'd8;
    tick();
    fill_start = 0;
    fill_valid = 1; fill_data = 3'd2; wr_en = 1; wr_sel = 5'd8; wr_data = 3'd7;
    tick();
    wr_en = 0;
    n_checks++;
    if (slot(8) !== 3'd7 || valid_out[8] !== 1'b1)
      $display("FAIL collision_slot8: got %0d v%b want 7 v1", slot(8), valid_out[8]);
    else n_pass++;
    fill_data = 3'd5;
    tick();
    n_checks++;
    if (slot(9) !== 3'd5 || slot(8) !== 3'd7)
      $display("FAIL collision_next: got s9=%0d s8=%0d want 5 7", slot(9), slot(8));
    else n_pass++;
    fill_data = 3'd1; tick();
    fill_data = 3'd6; tick();
    fill_valid = 0;
    n_checks++;
    if (fill_done !== 1'b1 || slot(11) !== 3'd6)
      $display("FAIL collision_count: got done=%b s11=%0d want 1 6", fill_done, slot(11));
    else n_pass++;
    tick();
  endtask

  task automatic test_start_ignored();
    fill_start = 1; fill_base = 5'd12;
    tick();
    fill_valid = 1; fill_data = 3'd3; fill_base = 5'd20;
    tick();
    fill_valid = 0;
    tick();
    fill_start = 0;
    fill_valid = 1; fill_data = 3'd4;
    tick();
    n_checks++;
    if (slot(13) !== 3'd4 || valid_out[20] !== 1'b0)
      $display("FAIL start_in_fill: got s13=%0d v20=%b want 4 0", slot(13), valid_out[20]);
    else n_pass++;
    fill_data = 3'd5; tick();
    fill_data = 3'd6; tick();
    fill_valid = 0; fill_start = 1; fill_base = 5'd20;
    tick();
    fill_start = 0;
    n_checks++;
    if (fill_busy !== 1'b0 || fill_ready !== 1'b0)
      $display("FAIL start_in_done: got busy=%b ready=%b want 0 0", fill_busy, fill_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (fill_busy !== 1'b0 || slot(15) !== 3'd6 || valid_out[20] !== 1'b0)
      $display("FAIL start_no_second: got busy=%b s15=%0d v20=%b want 0 6 0", fill_busy, slot(15), valid_out[20]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    fill_start = 1; fill_base = 5'd2;
    tick();
    fill_start = 0; fill_valid = 1;
    fill_data = 3'd7; tick();
    fill_data = 3'd7; tick();
    fill_valid = 0; rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if ({fill_ready, fill_busy, fill_done} !== 3'b000 || data_out !== '0 || valid_out !== '0)
      $display("FAIL reset_mid: got flags=%b data=%h valid=%h want 000 0 0",
               {fill_ready, fill_busy, fill_done}, data_out, valid_out);
    else n_pass++;
    inv_all = 1; wr_en = 1; wr_sel = 5'd3; wr_data = 3'd6; fill_valid = 1; fill_data = 3'd5;
    tick();
    idle_inputs();
    n_checks++;
    if (valid_out[3] !== 1'b0 || slot(3) !== 3'd6 || valid_out !== '0)
      $display("FAIL inv_priority: got v3=%b s3=%0d valid=%h want 0 6 0", valid_out[3], slot(3), valid_out);
    else n_pass++;
    n_checks++;
    if (data_out !== exp_bus() || fill_busy !== 1'b0)
      $display("FAIL idle_beat_ignored: got %h busy=%b want %h 0", data_out, fill_busy, exp_bus());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_sel     = 5'($urandom);
      wr_data    = 3'($urandom);
      inv_all    = ($urandom_range(0, 29) == 0);
      fill_start = ($urandom_range(0, 3) == 0);
      fill_base  = 5'($urandom);
      fill_valid = $urandom_range(0, 1) == 1;
      fill_data  = 3'($urandom);
      tick();
      n_checks++;
      if (data_out !== exp_bus() || valid_out !== exp_valid() ||
          {fill_ready, fill_busy, fill_done} !== exp_flags())
        $display("FAIL random_%0d: got %h/%h/%b want %h/%h/%b", i, data_out, valid_out,
                 {fill_ready, fill_busy, fill_done}, exp_bus(), exp_valid(), exp_flags());
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < W; k++) begin m_data[k] = 0; m_valid[k] = 0; end
    m_phase = P_IDLE; m_ptr = 0; m_cnt = 0;
    test_reset();
    test_single_write();
    test_wrapped_burst();
    test_collision();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
